mtl2_video_out_timing: RTL
==========================

// Module: mtl2_video_out_timing
// PURPOSE
//  Clocked-video output stage for the MTL2 800x480 panel and the VGA port: consumes a packetised
//  24-bit RGB pixel stream from the frame-buffer reader and emits pixel data plus H/V sync and
//  data-valid, timed to the panel. It sits between the SOPC video pipeline and the top-level pins.
//  The top level inverts vid_h_sync and vid_v_sync. The block free-runs its timing and re-locks to
//  the stream on start-of-packet. On starvation it outputs black and flags underflow.
// PARAMETERS
//  DW       24   pixel width, {R[7:0],G[7:0],B[7:0]}
//  H_ACTIVE 800  active pixels per line
//  H_FP     210  horizontal front porch (clocks)
//  H_SYNC   30   horizontal sync width
//  H_BP     16   horizontal back porch; H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=1056
//  V_ACTIVE 480  active lines
//  V_FP     22   vertical front porch (lines)
//  V_SYNC   13   vertical sync width
//  V_BP     10   vertical back porch; V_TOTAL=525
// PORTS
//  vid_clk         in   1   pixel clock (33 MHz from vga_pll c0); single clock domain
//  areset          in   1   asynchronous, active-high reset
//  in_data         in   DW  stream pixel
//  in_valid        in   1   in_data valid
//  in_sop          in   1   marks first pixel (0,0) of a frame; qualified by in_valid
//  in_ready        out  1   sink ready; beat transfers when in_valid & in_ready
//  vid_data        out  DW  pixel to panel/DAC; 0 outside active region
//  vid_datavalid   out  1   high during active region
//  vid_h_sync      out  1   active-high horizontal sync
//  vid_v_sync      out  1   active-high vertical sync
//  vid_underflow   out  1   one-cycle pulse per underflow/resync event
//  vid_locked      out  1   high while in RUN state
//  underflow_count out  16  saturating count of underflow events since reset
// BEHAVIOUR
//  - Reset (async assert, sync release): h_cnt=v_cnt=0; state WAIT_SOP; every output 0.
//  - Counters: h_cnt 0..H_TOTAL-1 wraps, v_cnt increments on h wrap, wraps at V_TOTAL-1. Counters
//    free-run in every state. Line order: active [0,H_ACTIVE), FP, SYNC, BP; same order vertically.
//  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. hs = h_cnt in [H_ACTIVE+H_FP, +H_SYNC).
//    vs = v_cnt in [V_ACTIVE+V_FP, +V_SYNC), whole lines.
//  - All video outputs are registered: 1 vid_clk latency from counter value. data, datavalid, hs
//    and vs are mutually aligned.
//  - in_ready is a function of state and counters only, never of in_valid.
//  - State WAIT_SOP:
//    - in_ready=1 for non-SOP beats, which are dropped.
//    - in_ready=0 while in_sop & in_valid, so the SOP beat is held.
//    - Move to RUN at the cycle where h_cnt=0 && v_cnt=0 with the SOP beat pending. That beat
//      transfers in that cycle.
//    - Outputs are black; datavalid still follows timing.
//  - State RUN:
//    - in_ready=active. A transfer drives vid_data next cycle.
//    - Active pixel with in_valid=0: vid_data=0, vid_underflow pulses, count+1, go to WAIT_SOP.
//    - in_sop on any transfer except (0,0): beat not consumed (in_ready forced 0 for it),
//      underflow pulse, count+1, go to WAIT_SOP.
//    - Pixel (0,0) beat without in_sop: same resync action.
//  - underflow_count saturates at 16'hFFFF. Multiple causes in one cycle count once.
//  - Reset mid-frame: immediate return to reset values; re-lock needs the next SOP.
// TESTING
//  1. Reset, source always valid, SOP at pixel 0 -> lock at first (0,0); datavalid 800 clk/line,
//     480 lines; hs period 1056; vs period 554400 clk, width 13 lines; underflow_count=0.
//  2. Ramp stream (pixel n = n) -> vid_data at active (x,y) = y*800+x, one clk after counter;
//     0 in blanking.
//  3. Drop in_valid at pixel (100,5) -> vid_data=0 there, one underflow pulse, vid_locked=0.
//     Re-locks at the next frame's (0,0); count=1.
//  4. Stream starts mid-frame with non-SOP beats -> beats drained while in_ready=1; SOP held
//     (in_ready=0) until (0,0); then locked.
//  5. SOP injected at pixel (400,200) -> SOP beat not accepted, underflow pulse, re-lock at next
//     frame using that same beat.
//  6. Assert areset at (500,300) in RUN -> all outputs 0 asynchronously; after release, counters
//     restart at 0,0 and the state is WAIT_SOP.

Source files
------------

// File: rtl/mtl2_video_out_timing.sv
// Clocked-video output stage for the MTL2 800x480 panel / VGA port.
// Free-running raster timing that locks a packetised RGB stream to pixel (0,0) and blanks on starvation.
module mtl2_video_out_timing #(
  parameter int DW       = 24,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 30,
  parameter int H_BP     = 16,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 13,
  parameter int V_BP     = 10
) (
  input  logic          vid_clk,
  input  logic          areset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_sop,
  output logic          in_ready,
  output logic [DW-1:0] vid_data,
  output logic          vid_datavalid,
  output logic          vid_h_sync,
  output logic          vid_v_sync,
  output logic          vid_underflow,
  output logic          vid_locked,
  output logic [15:0]   underflow_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [0:0] S_WAIT_SOP = 1'b0;
  localparam logic [0:0] S_RUN      = 1'b1;

  logic          rst_meta;
  logic          rst;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [0:0]    state;
  logic [0:0]    state_next;
  logic          at_origin;
  logic          active;
  logic          hs;
  logic          vs;
  logic          xfer;
  logic          lock_xfer;
  logic          show;
  logic          resync;

  // NOTE: areset asserts the internal reset immediately but its release is
  // retimed through two flops, so every state flop leaves reset on the same edge.
  always_ff @(posedge vid_clk or posedge areset) begin
    if (areset) begin
      rst_meta <= 1'b1;
      rst      <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst      <= rst_meta;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge vid_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs        = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign vs        = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);

  // Ready never looks at in_valid. An SOP beat is only taken at (0,0); any
  // other beat is taken only where it can be consumed.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (state == S_WAIT_SOP) in_ready = in_sop ? at_origin : 1'b1;
      else                     in_ready = active && (in_sop == at_origin);
    end
  end

  assign xfer      = in_valid && in_ready;
  assign lock_xfer = (state == S_WAIT_SOP) && xfer && in_sop;
  assign show      = lock_xfer || ((state == S_RUN) && xfer);

  // Starved active pixel, a misplaced SOP, or a missing SOP at (0,0).
  assign resync = (state == S_RUN) && active && (!in_valid || (in_sop != at_origin));

  always_comb begin
    state_next = state;
    case (state)
      S_WAIT_SOP: if (lock_xfer) state_next = S_RUN;
      S_RUN:      if (resync)    state_next = S_WAIT_SOP;
      default:    state_next = S_WAIT_SOP;
    endcase
  end

  always_ff @(posedge vid_clk or posedge rst) begin
    if (rst) begin
      state           <= S_WAIT_SOP;
      vid_data        <= '0;
      vid_datavalid   <= 1'b0;
      vid_h_sync      <= 1'b0;
      vid_v_sync      <= 1'b0;
      vid_underflow   <= 1'b0;
      underflow_count <= '0;
    end else begin
      state         <= state_next;
      vid_data      <= show ? in_data : '0;
      vid_datavalid <= active;
      vid_h_sync    <= hs;
      vid_v_sync    <= vs;
      vid_underflow <= resync;
      if (resync && (underflow_count != 16'hFFFF))
        underflow_count <= underflow_count + 1'b1;
    end
  end

  assign vid_locked = (state == S_RUN);

endmodule
